reservation_station: RTL and testbench

- Downstream of the dispatcher in the Tomasulo out-of-order core.
- Buffers decoded non-memory instructions with their operand values or ROB tags.
- Snoops both CDB ports (ALU and LSB) to wake up waiting operands.
- Each cycle, issues at most one fully-ready entry to the ALU; signals back-pressure to the dispatcher.

---
 rtl/reservation_station_pkg.sv | 63 ++++++
 rtl/reservation_station_if.sv | 51 +++++
 rtl/rs_lowest_one.sv | 22 ++
 rtl/reservation_station.sv | 124 ++++++++++++
 tb/tb_reservation_station.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and operand/entry types for the reservation station.
// Also holds the CDB snoop helper used at allocation and for wakeup.
package reservation_station_pkg;

  localparam int RS_SIZE    = 16;
  localparam int RS_IDX_LEN = 4;
  localparam int ROB_LEN    = 4;
  localparam int DATA_LEN   = 32;
  localparam int OPENUM_LEN = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [ROB_LEN-1:0] NO_DEP = '0;

  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP  = 6'd0;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADD  = 6'd1;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SUB  = 6'd2;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AND  = 6'd3;
  localparam logic [OPENUM_LEN-1:0] OPENUM_OR   = 6'd4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_XOR  = 6'd5;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLL  = 6'd6;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRL  = 6'd7;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRA  = 6'd8;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLT  = 6'd9;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTU = 6'd10;

  typedef logic [ROB_LEN-1:0]  tag_t;
  typedef logic [DATA_LEN-1:0] data_t;

  typedef struct packed {
    tag_t  q;
    data_t v;
  } operand_t;

  typedef struct packed {
    logic [OPENUM_LEN-1:0] openum;
    operand_t              op1;
    operand_t              op2;
    data_t                 pc;
    data_t                 imm;
    tag_t                  rob_id;
  } rs_entry_t;

  // ALU port wins if both ports carry the same tag (illegal upstream anyway).
  function automatic operand_t snoop(operand_t op,
                                     logic alu_vld, tag_t alu_tag, data_t alu_res,
                                     logic lsb_vld, tag_t lsb_tag, data_t lsb_res);
    operand_t r;
    r = op;
    if (op.q != NO_DEP) begin
      if (alu_vld && alu_tag == op.q) begin
        r.q = NO_DEP;
        r.v = alu_res;
      end else if (lsb_vld && lsb_tag == op.q) begin
        r.q = NO_DEP;
        r.v = lsb_res;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher, CDB, rollback and ALU-issue signals of the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic                  ena_from_dsp;
  logic [OPENUM_LEN-1:0] openum_from_dsp;
  data_t                 V1_from_dsp;
  data_t                 V2_from_dsp;
  tag_t                  Q1_from_dsp;
  tag_t                  Q2_from_dsp;
  data_t                 pc_from_dsp;
  data_t                 imm_from_dsp;
  tag_t                  rob_id_from_dsp;
  logic                  full_to_dsp;

  logic                  valid_alu_cdb;
  tag_t                  rob_id_alu_cdb;
  data_t                 result_alu_cdb;
  logic                  valid_lsb_cdb;
  tag_t                  rob_id_lsb_cdb;
  data_t                 result_lsb_cdb;

  logic                  rollback_from_rob;

  logic                  ena_to_alu;
  logic [OPENUM_LEN-1:0] openum_to_alu;
  data_t                 V1_to_alu;
  data_t                 V2_to_alu;
  data_t                 pc_to_alu;
  data_t                 imm_to_alu;
  tag_t                  rob_id_to_alu;

  modport master (
    output ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp, Q1_from_dsp,
           Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
           valid_alu_cdb, rob_id_alu_cdb, result_alu_cdb,
           valid_lsb_cdb, rob_id_lsb_cdb, result_lsb_cdb, rollback_from_rob,
    input  full_to_dsp, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
           pc_to_alu, imm_to_alu, rob_id_to_alu
  );

  modport slave (
    input  ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp, Q1_from_dsp,
           Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
           valid_alu_cdb, rob_id_alu_cdb, result_alu_cdb,
           valid_lsb_cdb, rob_id_lsb_cdb, result_lsb_cdb, rollback_from_rob,
    output full_to_dsp, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
           pc_to_alu, imm_to_alu, rob_id_to_alu
  );

endinterface

// File: rtl/rs_lowest_one.sv
// Lowest-set-bit priority encoder: found plus index of the lowest 1 in vec (combinational).
module rs_lowest_one #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo RS: buffers dispatched ops, wakes operands from both CDBs, issues lowest ready entry;
// ready-at-alloc ops reach the ALU two edges later; registered full_to_dsp keeps one slot of slack. Optional RS_PERF_COUNTERS_EN.
module reservation_station
  import reservation_station_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  reservation_station_if.slave bus
`ifdef RS_PERF_COUNTERS_EN
  ,
  output logic [31:0]         perf_full_cycles,
  output logic [31:0]         perf_issue_cnt
`endif
);

  localparam logic [RS_IDX_LEN:0] FULL_MARK = (RS_IDX_LEN+1)'(RS_SIZE - 1);

  rs_entry_t               ent [RS_SIZE];
  logic [RS_SIZE-1:0]      busy;
  logic [RS_SIZE-1:0]      free_vec;
  logic [RS_SIZE-1:0]      ready_vec;
  logic                    alloc_found;
  logic                    sel_found;
  logic                    alloc_fire;
  logic [RS_IDX_LEN-1:0]   alloc_idx;
  logic [RS_IDX_LEN-1:0]   sel_idx;
  logic [RS_IDX_LEN:0]     busy_cnt;
  logic [RS_IDX_LEN:0]     cnt_next;
  operand_t                in_op1;
  operand_t                in_op2;

  function automatic operand_t wake(operand_t op);
    return snoop(op, bus.valid_alu_cdb, bus.rob_id_alu_cdb, bus.result_alu_cdb,
                 bus.valid_lsb_cdb, bus.rob_id_lsb_cdb, bus.result_lsb_cdb);
  endfunction

  always_comb begin
    free_vec  = ~busy;
    ready_vec = '0;
    busy_cnt  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && ent[i].op1.q == NO_DEP && ent[i].op2.q == NO_DEP;
      busy_cnt     = busy_cnt + {{RS_IDX_LEN{1'b0}}, busy[i]};
    end
    alloc_fire = bus.ena_from_dsp && alloc_found;
    cnt_next   = busy_cnt - {{RS_IDX_LEN{1'b0}}, sel_found} + {{RS_IDX_LEN{1'b0}}, alloc_fire};
    in_op1     = wake({bus.Q1_from_dsp, bus.V1_from_dsp});
    in_op2     = wake({bus.Q2_from_dsp, bus.V2_from_dsp});
  end

  rs_lowest_one #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_LEN)) u_free_enc (
    .vec   (free_vec),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  rs_lowest_one #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_LEN)) u_ready_enc (
    .vec   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Alloc targets a free slot and select/wakeup touch busy slots, so writes never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy              <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      bus.full_to_dsp   <= FALSE;
      bus.ena_to_alu    <= FALSE;
      bus.openum_to_alu <= '0;
      bus.V1_to_alu     <= '0;
      bus.V2_to_alu     <= '0;
      bus.pc_to_alu     <= '0;
      bus.imm_to_alu    <= '0;
      bus.rob_id_to_alu <= '0;
    end else if (bus.rollback_from_rob) begin
      busy            <= '0;
      bus.full_to_dsp <= FALSE;
      bus.ena_to_alu  <= FALSE;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].op1 <= wake(ent[i].op1);
          ent[i].op2 <= wake(ent[i].op2);
        end
      end
      bus.ena_to_alu  <= sel_found;
      bus.full_to_dsp <= cnt_next >= FULL_MARK;
      if (sel_found) begin
        busy[sel_idx]     <= FALSE;
        bus.openum_to_alu <= ent[sel_idx].openum;
        bus.V1_to_alu     <= ent[sel_idx].op1.v;
        bus.V2_to_alu     <= ent[sel_idx].op2.v;
        bus.pc_to_alu     <= ent[sel_idx].pc;
        bus.imm_to_alu    <= ent[sel_idx].imm;
        bus.rob_id_to_alu <= ent[sel_idx].rob_id;
      end
      if (alloc_fire) begin
        busy[alloc_idx] <= TRUE;
        ent[alloc_idx]  <= '{openum: bus.openum_from_dsp, op1: in_op1, op2: in_op2,
                             pc: bus.pc_from_dsp, imm: bus.imm_from_dsp,
                             rob_id: bus.rob_id_from_dsp};
      end
    end
  end

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst)
    (bus.ena_from_dsp && !bus.rollback_from_rob) |-> alloc_found);

`ifdef RS_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_full_cycles <= '0;
      perf_issue_cnt   <= '0;
    end else begin
      if (bus.full_to_dsp && perf_full_cycles != 32'hFFFF_FFFF)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (bus.ena_to_alu && perf_issue_cnt != 32'hFFFF_FFFF)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected ALU issues queued at stimulus time, checked on ena_to_alu.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reservation_station_if bus ();

`ifdef RS_PERF_COUNTERS_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_issue_cnt;
`endif

  reservation_station dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RS_PERF_COUNTERS_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_issue_cnt   (perf_issue_cnt)
`endif
  );

  typedef struct {
    logic [OPENUM_LEN-1:0] op;
    data_t                 v1;
    data_t                 v2;
    data_t                 pc;
    data_t                 imm;
    tag_t                  rob;
    int                    cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic data_t pc_of(tag_t r);
    return 32'h0000_0100 + {26'd0, r, 2'b00};
  endfunction

  function automatic data_t imm_of(tag_t r);
    return 32'h0000_0050 + {28'd0, r};
  endfunction

  task automatic idle();
    bus.ena_from_dsp      = 1'b0;
    bus.valid_alu_cdb     = 1'b0;
    bus.valid_lsb_cdb     = 1'b0;
    bus.rollback_from_rob = 1'b0;
  endtask

  task automatic dsp(input logic [OPENUM_LEN-1:0] op, input data_t v1, input tag_t q1,
                     input data_t v2, input tag_t q2, input tag_t rob);
    bus.ena_from_dsp    = 1'b1;
    bus.openum_from_dsp = op;
    bus.V1_from_dsp     = v1;
    bus.Q1_from_dsp     = q1;
    bus.V2_from_dsp     = v2;
    bus.Q2_from_dsp     = q2;
    bus.pc_from_dsp     = pc_of(rob);
    bus.imm_from_dsp    = imm_of(rob);
    bus.rob_id_from_dsp = rob;
  endtask

  task automatic alu_cdb(input tag_t t, input data_t r);
    bus.valid_alu_cdb  = 1'b1;
    bus.rob_id_alu_cdb = t;
    bus.result_alu_cdb = r;
  endtask

  task automatic push(input logic [OPENUM_LEN-1:0] op, input data_t v1, input data_t v2,
                      input tag_t rob, input int c);
    sb.push_back('{op: op, v1: v1, v2: v2, pc: pc_of(rob), imm: imm_of(rob), rob: rob, cyc: c});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every issue must match the oldest expectation, at the expected cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && bus.ena_to_alu) begin
      if (sb.size() == 0) begin
        chk("spurious_issue", 64'(bus.rob_id_to_alu), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(e.cyc));
        chk("openum", 64'(bus.openum_to_alu), 64'(e.op));
        chk("V1", 64'(bus.V1_to_alu), 64'(e.v1));
        chk("V2", 64'(bus.V2_to_alu), 64'(e.v2));
        chk("pc", 64'(bus.pc_to_alu), 64'(e.pc));
        chk("imm", 64'(bus.imm_to_alu), 64'(e.imm));
        chk("rob_id", 64'(bus.rob_id_to_alu), 64'(e.rob));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1);
  end

  initial begin
    idle();
    dsp(OPENUM_NOP, '0, NO_DEP, '0, NO_DEP, NO_DEP);
    bus.ena_from_dsp   = 1'b0;
    bus.rob_id_alu_cdb = '0;
    bus.result_alu_cdb = '0;
    bus.rob_id_lsb_cdb = '0;
    bus.result_lsb_cdb = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ena", 64'(bus.ena_to_alu), 64'd0);
    chk("rst_full", 64'(bus.full_to_dsp), 64'd0);
    chk("rst_V1", 64'(bus.V1_to_alu), 64'd0);
    chk("rst_rob", 64'(bus.rob_id_to_alu), 64'd0);
    rst = 1'b1;
    step();

    // Ready at allocation.
    dsp(OPENUM_ADD, 32'd5, NO_DEP, 32'd7, NO_DEP, 4'd3);
    push(OPENUM_ADD, 32'd5, 32'd7, 4'd3, cyc + 2);
    step(); idle();
    drain("t1_drain", 10);

    // Wakeup from ALU CDB two cycles after dispatch.
    dsp(OPENUM_SUB, 32'hBAD, 4'd2, 32'd10, NO_DEP, 4'd4);
    step(); idle();
    step();
    alu_cdb(4'd2, 32'd30);
    push(OPENUM_SUB, 32'd30, 32'd10, 4'd4, cyc + 2);
    step(); idle();
    drain("t2_drain", 10);

    // Same-cycle bypass from LSB CDB.
    dsp(OPENUM_OR, 32'd0, 4'd4, 32'd1, NO_DEP, 4'd5);
    bus.valid_lsb_cdb  = 1'b1;
    bus.rob_id_lsb_cdb = 4'd4;
    bus.result_lsb_cdb = 32'hDEAD_BEEF;
    push(OPENUM_OR, 32'hDEAD_BEEF, 32'd1, 4'd5, cyc + 2);
    step(); idle();
    drain("t3_drain", 10);

    // Fill with 15 waiting entries, then drain in index order.
    for (int k = 0; k < 15; k++) begin
      dsp(OPENUM_AND, 32'd0, 4'd1, 32'(k), NO_DEP, tag_t'(k + 1));
      step();
      if (k == 13) chk("full_at_14", 64'(bus.full_to_dsp), 64'd0);
      if (k == 14) chk("full_at_15", 64'(bus.full_to_dsp), 64'd1);
    end
    idle();
    step(); step();
    alu_cdb(4'd1, 32'd9);
    for (int k = 0; k < 15; k++) push(OPENUM_AND, 32'd9, 32'(k), tag_t'(k + 1), cyc + 2 + k);
    step(); idle();
    drain("t4_drain", 40);
    chk("full_after_drain", 64'(bus.full_to_dsp), 64'd0);

    // Rollback: 8 waiting entries plus one that would issue on the rollback edge.
    for (int k = 0; k < 8; k++) begin
      dsp(OPENUM_XOR, 32'd0, 4'd6, 32'(k), NO_DEP, tag_t'(k + 1));
      step();
    end
    dsp(OPENUM_XOR, 32'd1, NO_DEP, 32'd2, NO_DEP, 4'd9);
    step();
    dsp(OPENUM_ADD, 32'd3, NO_DEP, 32'd4, NO_DEP, 4'd10);
    alu_cdb(4'd6, 32'd77);
    bus.rollback_from_rob = 1'b1;
    step(); idle();
    chk("rb_full", 64'(bus.full_to_dsp), 64'd0);
    chk("rb_ena", 64'(bus.ena_to_alu), 64'd0);
    alu_cdb(4'd6, 32'd77);
    step(); idle();
    repeat (5) step();
    dsp(OPENUM_ADD, 32'd11, NO_DEP, 32'd22, NO_DEP, 4'd12);
    push(OPENUM_ADD, 32'd11, 32'd22, 4'd12, cyc + 2);
    step(); idle();
    drain("t5_drain", 10);

    // Async reset mid-cycle while issuing with the station full.
    for (int k = 0; k < 15; k++) begin
      dsp(OPENUM_SRL, 32'd0, 4'd8, 32'(k), NO_DEP, tag_t'(k + 1));
      step();
    end
    dsp(OPENUM_SLT, 32'd100, NO_DEP, 32'd200, NO_DEP, 4'd13);
    push(OPENUM_SLT, 32'd100, 32'd200, 4'd13, cyc + 2);
    step(); idle();
    for (int i = 0; i < 5 && !bus.ena_to_alu; i++) begin
      @(posedge clk);
      #2;
    end
    chk("pre_reset_ena", 64'(bus.ena_to_alu), 64'd1);
    chk("pre_reset_full", 64'(bus.full_to_dsp), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_ena", 64'(bus.ena_to_alu), 64'd0);
    chk("async_full", 64'(bus.full_to_dsp), 64'd0);
    chk("async_V1", 64'(bus.V1_to_alu), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    step();
    alu_cdb(4'd8, 32'd55);
    step(); idle();
    repeat (4) step();
    dsp(OPENUM_SUB, 32'd7, NO_DEP, 32'd3, NO_DEP, 4'd14);
    push(OPENUM_SUB, 32'd7, 32'd3, 4'd14, cyc + 2);
    step(); idle();
    drain("t6_drain", 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
